// File: rtl/synth_pkg.sv
// Shared types for the synth voice blocks: per-voice state encoding and the
// note code meaning "no note".
package synth_pkg;
  typedef enum logic [1:0] {IDLE, HELD, SUST, REL} voice_state_t;
  localparam int NOTE_NONE = 0;
endpackage

// File: rtl/sustain_poly_if.sv
// Keyboard-side inputs and per-voice outputs of the polyphonic sustain block.
interface sustain_poly_if #(
  parameter int NOTE_W = 5,
  parameter int VOICES = 4
);
  logic                       sustain_button;
  logic                       key_pressed;
  logic [NOTE_W-1:0]          current_note_on_key;
  logic [VOICES*NOTE_W-1:0]   voice_note;
  logic [VOICES-1:0]          voice_active;
  logic [VOICES-1:0]          voice_release;
  logic                       steal;

  modport master (
    output sustain_button, key_pressed, current_note_on_key,
    input  voice_note, voice_active, voice_release, steal
  );
  modport slave (
    input  sustain_button, key_pressed, current_note_on_key,
    output voice_note, voice_active, voice_release, steal
  );
endinterface

// File: rtl/sustain_voice.sv
// One voice slot: IDLE/HELD/SUST/REL state, note register and release down-counter.
// load wins over keyoff, which wins over pedal_release.
module sustain_voice
  import synth_pkg::*;
#(
  parameter int NOTE_W     = 5,
  parameter int REL_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [NOTE_W-1:0] load_note,
  input  logic              keyoff,
  input  logic              sustain,
  input  logic              pedal_release,
  output logic [NOTE_W-1:0] note,
  output logic              active,
  output logic              held,
  output logic              releasing
);
  localparam int CW = $clog2(REL_CYCLES + 1);
  localparam logic [CW-1:0] REL_LAST = CW'(REL_CYCLES - 1);

  voice_state_t      state_q, state_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      note_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = HELD;
      note_d  = load_note;
      cnt_d   = '0;
    end else if (keyoff && state_q == HELD) begin
      if (sustain) begin
        state_d = SUST;
      end else begin
        state_d = REL;
        cnt_d   = REL_LAST;
      end
    end else if (pedal_release && state_q == SUST) begin
      state_d = REL;
      cnt_d   = REL_LAST;
    end else if (state_q == REL) begin
      // cnt==0 is the last REL cycle, so the tail lasts exactly REL_CYCLES
      if (cnt_q == '0) begin
        state_d = IDLE;
        note_d  = NOTE_W'(NOTE_NONE);
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  assign note      = note_q;
  assign active    = (state_q != IDLE);
  assign held      = (state_q == HELD);
  assign releasing = (state_q == REL);
endmodule

// File: rtl/sustain_poly.sv
// Polyphonic sustain: key-on/key-off/pedal event detection, voice allocation
// (match, lowest free, round-robin steal) and VOICES sustain_voice slots.
module sustain_poly
  import synth_pkg::*;
#(
  parameter int NOTE_W     = 5,
  parameter int VOICES     = 4,
  parameter int REL_CYCLES = 50000
) (
  input  logic           clock,
  input  logic           reset,
  sustain_poly_if.slave  bus
);
  localparam int PW = (VOICES > 1) ? $clog2(VOICES) : 1;

  logic              key_q, sus_q, steal_q;
  logic [NOTE_W-1:0] note_q;
  logic [PW-1:0]     steal_ptr;

  logic [VOICES-1:0][NOTE_W-1:0] vnote;
  logic [VOICES-1:0] active, held, rel_vec, load_vec, off_vec;

  logic          key_on, key_off, pedal_rel, do_steal;
  logic          match_any, free_any, off_any;
  logic [PW-1:0] match_idx, free_idx, off_idx, victim;

  assign key_on    = bus.key_pressed && (bus.current_note_on_key != NOTE_W'(NOTE_NONE)) &&
                     (!key_q || bus.current_note_on_key != note_q);
  assign key_off   = key_q && (note_q != NOTE_W'(NOTE_NONE)) &&
                     (!bus.key_pressed || bus.current_note_on_key != note_q);
  assign pedal_rel = !bus.sustain_button && sus_q;

  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    off_any   = 1'b0;
    off_idx   = '0;
    // descending scan so the lowest matching index wins
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (active[i] && vnote[i] == bus.current_note_on_key) begin
        match_any = 1'b1;
        match_idx = PW'(i);
      end
      if (!active[i]) begin
        free_any = 1'b1;
        free_idx = PW'(i);
      end
      if (held[i] && vnote[i] == note_q) begin
        off_any = 1'b1;
        off_idx = PW'(i);
      end
    end
    victim   = match_any ? match_idx : (free_any ? free_idx : steal_ptr);
    do_steal = key_on && !match_any && !free_any;
    load_vec = '0;
    off_vec  = '0;
    if (key_on) load_vec[victim] = 1'b1;
    if (key_off && off_any && !(key_on && victim == off_idx)) off_vec[off_idx] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_q     <= 1'b0;
      note_q    <= '0;
      sus_q     <= 1'b0;
      steal_q   <= 1'b0;
      steal_ptr <= '0;
    end else begin
      key_q   <= bus.key_pressed;
      note_q  <= bus.current_note_on_key;
      sus_q   <= bus.sustain_button;
      steal_q <= do_steal;
      if (do_steal)
        steal_ptr <= (steal_ptr == PW'(VOICES - 1)) ? '0 : steal_ptr + PW'(1);
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_voice
    sustain_voice #(
      .NOTE_W     (NOTE_W),
      .REL_CYCLES (REL_CYCLES)
    ) u_voice (
      .clock         (clock),
      .reset         (reset),
      .load          (load_vec[g]),
      .load_note     (bus.current_note_on_key),
      .keyoff        (off_vec[g]),
      .sustain       (bus.sustain_button),
      .pedal_release (pedal_rel),
      .note          (vnote[g]),
      .active        (active[g]),
      .held          (held[g]),
      .releasing     (rel_vec[g])
    );
  end

  assign bus.voice_note    = vnote;
  assign bus.voice_active  = active;
  assign bus.voice_release = rel_vec;
  assign bus.steal         = steal_q;
endmodule

// File: tb/tb_sustain_poly.sv
// Directed vector bench for sustain_poly with VOICES=4, REL_CYCLES=4.
module tb_sustain_poly;
  localparam int NOTE_W = 5;
  localparam int VOICES = 4;
  localparam int REL    = 4;

  typedef struct {
    bit          sus;
    bit          key;
    logic [4:0]  note;
    logic [19:0] en;
    logic [3:0]  act;
    logic [3:0]  rel;
    bit          st;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   row   = 0;

  sustain_poly_if #(.NOTE_W(NOTE_W), .VOICES(VOICES)) bus ();

  sustain_poly #(.NOTE_W(NOTE_W), .VOICES(VOICES), .REL_CYCLES(REL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(bit sus, bit key, int note, int v3, int v2, int v1, int v0,
                              logic [3:0] act, logic [3:0] rel, bit st);
    vec_t v;
    v.sus  = sus;
    v.key  = key;
    v.note = 5'(note);
    v.en   = {5'(v3), 5'(v2), 5'(v1), 5'(v0)};
    v.act  = act;
    v.rel  = rel;
    v.st   = st;
    return v;
  endfunction

  task automatic chk(string name, logic [19:0] got, logic [19:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_row(vec_t v);
    bus.sustain_button      = v.sus;
    bus.key_pressed         = v.key;
    bus.current_note_on_key = v.note;
    @(posedge clock);
    #1;
    row++;
    chk($sformatf("row%0d voice_note", row),    bus.voice_note, v.en);
    chk($sformatf("row%0d voice_active", row),  20'(bus.voice_active), 20'(v.act));
    chk($sformatf("row%0d voice_release", row), 20'(bus.voice_release), 20'(v.rel));
    chk($sformatf("row%0d steal", row),         20'(bus.steal), 20'(v.st));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " voice_note"},    bus.voice_note, 20'h0);
    chk({tag, " voice_active"},  20'(bus.voice_active), 20'h0);
    chk({tag, " voice_release"}, 20'(bus.voice_release), 20'h0);
    chk({tag, " steal"},         20'(bus.steal), 20'h0);
  endtask

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  initial begin
    // single note, pedal up; key with note 0 first must not allocate
    tbl_a.push_back(mk(0,1,0, 0,0,0,0, 4'h0,4'h0,0));
    for (int i = 0; i < 3; i++) tbl_a.push_back(mk(0,1,5, 0,0,0,5, 4'h1,4'h0,0));
    for (int i = 0; i < REL; i++) tbl_a.push_back(mk(0,0,0, 0,0,0,5, 4'h1,4'h1,0));
    tbl_a.push_back(mk(0,0,0, 0,0,0,0, 4'h0,4'h0,0));
    // pedal latch of 3, 7, 9 then common release
    tbl_a.push_back(mk(1,1,3, 0,0,0,3, 4'h1,4'h0,0));
    tbl_a.push_back(mk(1,0,0, 0,0,0,3, 4'h1,4'h0,0));
    tbl_a.push_back(mk(1,1,7, 0,0,7,3, 4'h3,4'h0,0));
    tbl_a.push_back(mk(1,0,0, 0,0,7,3, 4'h3,4'h0,0));
    tbl_a.push_back(mk(1,1,9, 0,9,7,3, 4'h7,4'h0,0));
    tbl_a.push_back(mk(1,0,0, 0,9,7,3, 4'h7,4'h0,0));
    for (int i = 0; i < REL; i++) tbl_a.push_back(mk(0,0,0, 0,9,7,3, 4'h7,4'h7,0));
    tbl_a.push_back(mk(0,0,0, 0,0,0,0, 4'h0,4'h0,0));
    // fill all voices, then two round-robin steals
    tbl_a.push_back(mk(1,1,1, 0,0,0,1, 4'h1,4'h0,0));
    tbl_a.push_back(mk(1,0,0, 0,0,0,1, 4'h1,4'h0,0));
    tbl_a.push_back(mk(1,1,2, 0,0,2,1, 4'h3,4'h0,0));
    tbl_a.push_back(mk(1,0,0, 0,0,2,1, 4'h3,4'h0,0));
    tbl_a.push_back(mk(1,1,3, 0,3,2,1, 4'h7,4'h0,0));
    tbl_a.push_back(mk(1,0,0, 0,3,2,1, 4'h7,4'h0,0));
    tbl_a.push_back(mk(1,1,4, 4,3,2,1, 4'hf,4'h0,0));
    tbl_a.push_back(mk(1,0,0, 4,3,2,1, 4'hf,4'h0,0));
    tbl_a.push_back(mk(1,1,6, 4,3,2,6, 4'hf,4'h0,1));
    tbl_a.push_back(mk(1,0,0, 4,3,2,6, 4'hf,4'h0,0));
    tbl_a.push_back(mk(1,1,8, 4,3,8,6, 4'hf,4'h0,1));
    tbl_a.push_back(mk(1,0,0, 4,3,8,6, 4'hf,4'h0,0));
    for (int i = 0; i < REL; i++) tbl_a.push_back(mk(0,0,0, 4,3,8,6, 4'hf,4'hf,0));
    tbl_a.push_back(mk(0,0,0, 0,0,0,0, 4'h0,4'h0,0));
    // legato 5->7, then re-press 5 while its voice is releasing
    tbl_a.push_back(mk(0,1,5, 0,0,0,5, 4'h1,4'h0,0));
    tbl_a.push_back(mk(0,1,7, 0,0,7,5, 4'h3,4'h1,0));
    tbl_a.push_back(mk(0,1,5, 0,0,7,5, 4'h3,4'h2,0));
    for (int i = 0; i < 3; i++) tbl_a.push_back(mk(0,0,0, 0,0,7,5, 4'h3,4'h3,0));
    tbl_a.push_back(mk(0,0,0, 0,0,0,5, 4'h1,4'h1,0));
    tbl_a.push_back(mk(0,0,0, 0,0,0,0, 4'h0,4'h0,0));

    // after reset: allocation restarts at voice 0 and steal_ptr at 0
    tbl_b.push_back(mk(1,1,2, 0,0,0,2, 4'h1,4'h0,0));
    tbl_b.push_back(mk(1,0,0, 0,0,0,2, 4'h1,4'h0,0));
    tbl_b.push_back(mk(1,1,3, 0,0,3,2, 4'h3,4'h0,0));
    tbl_b.push_back(mk(1,0,0, 0,0,3,2, 4'h3,4'h0,0));
    tbl_b.push_back(mk(1,1,5, 0,5,3,2, 4'h7,4'h0,0));
    tbl_b.push_back(mk(1,0,0, 0,5,3,2, 4'h7,4'h0,0));
    tbl_b.push_back(mk(1,1,6, 6,5,3,2, 4'hf,4'h0,0));
    tbl_b.push_back(mk(1,0,0, 6,5,3,2, 4'hf,4'h0,0));
    tbl_b.push_back(mk(1,1,9, 6,5,3,9, 4'hf,4'h0,1));
    tbl_b.push_back(mk(1,1,9, 6,5,3,9, 4'hf,4'h0,0));

    bus.sustain_button      = 1'b0;
    bus.key_pressed         = 1'b0;
    bus.current_note_on_key = '0;
    #2;
    chk_zero("reset");
    #10 reset = 1'b0;

    foreach (tbl_a[i]) run_row(tbl_a[i]);

    // voice0 releasing note 2, voice1 holding 4, then async reset between edges
    run_row(mk(0,1,2, 0,0,0,2, 4'h1,4'h0,0));
    run_row(mk(0,1,4, 0,0,4,2, 4'h3,4'h1,0));
    #2 reset = 1'b1;
    #1;
    chk_zero("async reset");
    bus.key_pressed         = 1'b0;
    bus.current_note_on_key = '0;
    #2 reset = 1'b0;

    foreach (tbl_b[i]) run_row(tbl_b[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
